// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift register with counted burst-shift FSM
// Optional feature macro: USR_ROTATE_EN (adds input rot; shifts rotate instead of filling from serial inputs)
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] shift_cnt,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             rot_live;
  logic             rot_burst;

`ifdef USR_ROTATE_EN
  logic rot_q, rot_d;
  assign rot_live  = rot;
  assign rot_burst = rot_q;
`else
  assign rot_live  = 1'b0;
  assign rot_burst = 1'b0;
`endif

  // One shift step; in rotate mode the outgoing bit replaces the serial input
  function automatic logic [WIDTH-1:0] shift_fn(
    input logic [WIDTH-1:0] v,
    input logic             left,
    input logic             rot_on,
    input logic             s_r,
    input logic             s_l
  );
    logic fill_r;
    logic fill_l;
    fill_r = rot_on ? v[0] : s_r;
    fill_l = rot_on ? v[WIDTH-1] : s_l;
    return left ? {v[WIDTH-2:0], fill_l} : {fill_r, v[WIDTH-1:1]};
  endfunction

  // State and datapath registers; everything holds while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      q_q     <= '0;
`ifdef USR_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
`ifdef USR_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // Next state: burst start wins over manual mode in IDLE; inputs ignored elsewhere
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    q_d     = q_q;
`ifdef USR_ROTATE_EN
    rot_d   = rot_q;
`endif
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dir_d = dir;
`ifdef USR_ROTATE_EN
            rot_d = rot;
`endif
            if (shift_cnt != '0) begin
              q_d     = shift_fn(q_q, dir, rot_live, sin_r, sin_l);
              cnt_d   = shift_cnt - CNT_ONE;
              state_d = (shift_cnt > CNT_ONE) ? S_SHIFT : S_DONE;
            end else begin
              cnt_d   = '0;
              state_d = S_DONE;
            end
          end else begin
            case (mode)
              2'b01:   q_d = shift_fn(q_q, 1'b0, rot_live, sin_r, sin_l);
              2'b10:   q_d = shift_fn(q_q, 1'b1, rot_live, sin_r, sin_l);
              2'b11:   q_d = d;
              default: q_d = q_q;
            endcase
          end
        end
        S_SHIFT: begin
          q_d   = shift_fn(q_q, dir_q, rot_burst, sin_r, sin_l);
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only
  always_comb begin
    q      = q_q;
    sout_r = q_q[0];
    sout_l = q_q[WIDTH-1];
    busy   = (state_q == S_SHIFT);
    done   = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - scoreboard bench for universal_shift_reg
module tb_universal_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_r;
  logic       sin_l;
  logic       start;
  logic       dir;
  logic [3:0] shift_cnt;
`ifdef USR_ROTATE_EN
  logic       rot;
`endif
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .start     (start),
    .dir       (dir),
    .shift_cnt (shift_cnt),
`ifdef USR_ROTATE_EN
    .rot       (rot),
`endif
    .q         (q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.tag  = tag;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check_val({e.tag, ".q"},      64'(q),      64'(e.q));
      check_val({e.tag, ".sout_r"}, 64'(sout_r), 64'(e.q[0]));
      check_val({e.tag, ".sout_l"}, 64'(sout_l), 64'(e.q[7]));
      check_val({e.tag, ".busy"},   64'(busy),   64'(e.busy));
      check_val({e.tag, ".done"},   64'(done),   64'(e.done));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  mq;
    logic [15:0] tmp;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00;
    sin_r = 1'b0; sin_l = 1'b0; start = 1'b0; dir = 1'b0; shift_cnt = 4'd0;
`ifdef USR_ROTATE_EN
    rot = 1'b0;
`endif
    #1;
    check_val("rst.q",      64'(q),      64'h0);
    check_val("rst.busy",   64'(busy),   64'h0);
    check_val("rst.done",   64'(done),   64'h0);
    check_val("rst.sout_r", 64'(sout_r), 64'h0);
    check_val("rst.sout_l", 64'(sout_l), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;

    // manual load / shift right / shift left / hold / enable low
    mode = 2'b11; d = 8'h3C; push_exp("load", 8'h3C, 1'b0, 1'b0); tick_check();
    mode = 2'b01; sin_r = 1'b1; push_exp("shr1", 8'h9E, 1'b0, 1'b0); tick_check();
    push_exp("shr2", 8'hCF, 1'b0, 1'b0); tick_check();
    mode = 2'b10; sin_l = 1'b1; push_exp("shl", 8'h9F, 1'b0, 1'b0); tick_check();
    mode = 2'b00; push_exp("hold", 8'h9F, 1'b0, 1'b0); tick_check();
    en = 1'b0; mode = 2'b11; d = 8'h00; push_exp("en0", 8'h9F, 1'b0, 1'b0); tick_check();
    en = 1'b1;

    // burst left 3 from 0x81; mode load requested alongside start must be ignored
    d = 8'h81; push_exp("ld81", 8'h81, 1'b0, 1'b0); tick_check();
    start = 1'b1; dir = 1'b1; shift_cnt = 4'd3; sin_l = 1'b0; d = 8'hFF;
    push_exp("b3_1", 8'h02, 1'b1, 1'b0);
    push_exp("b3_2", 8'h04, 1'b1, 1'b0);
    push_exp("b3_3", 8'h08, 1'b0, 1'b1);
    push_exp("b3_4", 8'h08, 1'b0, 1'b0);
    tick_check();
    start = 1'b0; dir = 1'b0;
    tick_check();
    tick_check();
    tick_check();
    mode = 2'b00;

    // zero-length burst
    start = 1'b1; shift_cnt = 4'd0; mode = 2'b11;
    push_exp("z1", 8'h08, 1'b0, 1'b1);
    push_exp("z2", 8'h08, 1'b0, 1'b0);
    tick_check();
    start = 1'b0; mode = 2'b00;
    tick_check();

    // single right shift of 0x81 with sin_r=0
    mode = 2'b11; d = 8'h81; push_exp("ld81b", 8'h81, 1'b0, 1'b0); tick_check();
    mode = 2'b01; sin_r = 1'b0;
`ifdef USR_ROTATE_EN
    rot = 1'b1; push_exp("rotr", 8'hC0, 1'b0, 1'b0); tick_check(); rot = 1'b0;
`else
    push_exp("shr0", 8'h40, 1'b0, 1'b0); tick_check();
`endif
    mode = 2'b00;

    // burst right 4 from 0xF0 with a 2-cycle stall mid-burst and a stall while done
    mode = 2'b11; d = 8'hF0; push_exp("ldF0", 8'hF0, 1'b0, 1'b0); tick_check();
    mode = 2'b00; start = 1'b1; dir = 1'b0; shift_cnt = 4'd4; sin_r = 1'b0;
    push_exp("st1", 8'h78, 1'b1, 1'b0);
    push_exp("st2", 8'h3C, 1'b1, 1'b0);
    push_exp("st3", 8'h3C, 1'b1, 1'b0);
    push_exp("st4", 8'h3C, 1'b1, 1'b0);
    push_exp("st5", 8'h1E, 1'b1, 1'b0);
    push_exp("st6", 8'h0F, 1'b0, 1'b1);
    push_exp("st7", 8'h0F, 1'b0, 1'b1);
    push_exp("st8", 8'h0F, 1'b0, 1'b0);
    tick_check();
    start = 1'b0;
    tick_check();
    en = 1'b0; tick_check(); tick_check();
    en = 1'b1; tick_check(); tick_check();
    en = 1'b0; tick_check();
    en = 1'b1; tick_check();

    // maximum burst (15) left filling with ones, longer than the register width
    mode = 2'b11; d = 8'h00; push_exp("ld00", 8'h00, 1'b0, 1'b0); tick_check();
    mode = 2'b00; start = 1'b1; dir = 1'b1; shift_cnt = 4'd15; sin_l = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tmp = (16'h1 << k) - 16'h1;
      push_exp($sformatf("max%0d", k), (tmp > 16'h00FF) ? 8'hFF : tmp[7:0], k < 15, k == 15);
    end
    push_exp("max16", 8'hFF, 1'b0, 1'b0);
    tick_check();
    start = 1'b0;
    for (int k = 0; k < 15; k++) tick_check();

    // random manual operations against a reference shift model
    mq = 8'hFF;
    for (int i = 0; i < 24; i++) begin
      mode  = 2'($urandom_range(0, 3));
      d     = 8'($urandom);
      sin_r = 1'($urandom);
      sin_l = 1'($urandom);
      case (mode)
        2'b01:   mq = {sin_r, mq[7:1]};
        2'b10:   mq = {mq[6:0], sin_l};
        2'b11:   mq = d;
        default: mq = mq;
      endcase
      push_exp($sformatf("rnd%0d", i), mq, 1'b0, 1'b0);
      tick_check();
    end

    // reset in the middle of a burst
    mode = 2'b11; d = 8'hA5; push_exp("ldA5", 8'hA5, 1'b0, 1'b0); tick_check();
    mode = 2'b00; start = 1'b1; dir = 1'b0; shift_cnt = 4'd5; sin_r = 1'b0;
    push_exp("rb1", 8'h52, 1'b1, 1'b0); tick_check();
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rstmid.q",    64'(q),    64'h0);
    check_val("rstmid.busy", 64'(busy), 64'h0);
    check_val("rstmid.done", 64'(done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'b11; d = 8'h12; push_exp("post", 8'h12, 1'b0, 1'b0); tick_check();
    mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      push_exp($sformatf("postidle%0d", i), 8'h12, 1'b0, 1'b0);
      tick_check();
    end

    check_val("sb_left", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter CNT_W, default 4, width of burst shift count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  clock enable; low freezes q and FSM.
REQ-006 mode  input  2  manual op: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 sin_r  input  1  serial in for right shift, enters at MSB.
REQ-009 sin_l  input  1  serial in for left shift, enters at LSB.
REQ-010 start  input  1  burst shift request, sampled in IDLE only.
REQ-011 dir  input  1  burst direction, sampled with start: 0 right, 1 left.
REQ-012 shift_cnt  input  CNT_W  burst shift count, sampled with start.
REQ-013 q  output  WIDTH  register contents.
REQ-014 sout_r  output  1  q[0] (bit leaving on right shift).
REQ-015 sout_l  output  1  q[WIDTH-1] (bit leaving on left shift).
REQ-016 busy  output  1  high while FSM in SHIFT.
REQ-017 done  output  1  one-cycle pulse at burst completion.

Function
REQ-018 FSM states IDLE, SHIFT, DONE; all transitions qualified by en=1.
REQ-019 IDLE, start=0: mode applied each enabled cycle; right: q <= {sin_r, q[WIDTH-1:1]}; left: q <= {q[WIDTH-2:0], sin_l}; load: q <= d.
REQ-020 IDLE, start=1, shift_cnt>0: latch dir and shift_cnt-1 into remaining counter, perform first shift same edge, go SHIFT if shift_cnt>1 else DONE.
REQ-021 IDLE, start=1, shift_cnt=0: q unchanged, go DONE.
REQ-022 start has priority over mode in IDLE; mode ignored same cycle.
REQ-023 SHIFT: one shift per enabled cycle in latched dir using live sin_r/sin_l; counter decrements; at counter 1 final shift and go DONE.
REQ-024 Burst of N shifts completes exactly N enabled cycles after start edge; done high for one cycle following, FSM returns to IDLE.
REQ-025 DONE: q unchanged, mode and start ignored; next enabled edge to IDLE.
REQ-026 start, dir, shift_cnt, mode, d ignored outside IDLE.
REQ-027 en=0: q, counter, state held; done/busy hold value (done stays high until next enabled edge).
REQ-028 busy = (state==SHIFT); done = (state==DONE); both registered-state decodes, no input path.
REQ-029 Maximum burst 2**CNT_W-1 shifts; shifts beyond WIDTH fill entirely with serial input.

Reset
REQ-030 rst_n low asynchronously forces q=0, state IDLE, counter 0, busy=0, done=0, sout_r=0, sout_l=0.
REQ-031 Reset mid-burst aborts without done pulse; first post-reset edge behaves as IDLE.
REQ-032 Reset deassertion synchronous to clk by integrator; no internal synchroniser.

Configuration
REQ-033 Macro USR_ROTATE_EN defined: adds input rot (1 bit); rot=1 makes every shift (manual and burst, rot sampled with start for burst) rotate, outgoing bit replacing sin_r/sin_l.
REQ-034 USR_ROTATE_EN undefined: port rot absent, all shifts fill from serial inputs.

Verification
REQ-035 rst_n=0 mid-burst with q=8'hA5 -> q=8'h00, busy=0, done never pulses.
REQ-036 mode=11, d=8'h3C, then mode=01, sin_r=1, 2 cycles -> q=8'h3C, 8'h9E, 8'hCF.
REQ-037 q=8'h81, start=1, dir=1, shift_cnt=3, sin_l=0 -> busy 2 cycles, q=8'h08 after 3 edges, done pulse on 4th cycle.
REQ-038 start=1, shift_cnt=0 -> q unchanged, done pulses next cycle, busy never high.
REQ-039 Burst shift_cnt=4 with en=0 for 2 cycles mid-burst -> completion delayed exactly 2 cycles, q identical to no-stall run.
REQ-040 USR_ROTATE_EN, rot=1, q=8'h81, right shift once -> q=8'hC0; without macro same stimulus, sin_r=0 -> q=8'h40.
